// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
//   loader_state_t : loader FSM states
//   rx_state_t     : UART receive FSM states
//   CMD_START      : frame start marker
//   calc_div()     : clock cycles per UART bit (truncated)
package loader_pkg;

    localparam logic [7:0] CMD_START = 8'hA5;

    typedef enum logic [2:0] {
        L_IDLE  = 3'd0,
        L_COUNT = 3'd1,
        L_DATA  = 3'd2,
        L_CHECK = 3'd3,
        L_DONE  = 3'd4,
        L_ERR   = 3'd5
    } loader_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_inst_loader_if.sv
// Instruction memory write port.
//   we_o    : one-cycle write strobe
//   waddr_o : byte address, word aligned
//   wdata_o : 32-bit instruction word
interface uart_inst_loader_if;

    logic        we_o;
    logic [7:0]  waddr_o;
    logic [31:0] wdata_o;

    modport master (output we_o, output waddr_o, output wdata_o);
    modport slave  (input  we_o, input  waddr_o, input  wdata_o);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchronizer.
//   clock_reg, reset : clock and synchronous active-high reset
//   rxd              : asynchronous serial input, idle high
//   byte_valid       : one-cycle pulse, good stop bit seen
//   frame_err        : one-cycle pulse, stop bit was low
//   data             : last good byte, updated with byte_valid
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic       clock_reg,
    input  logic       reset,
    input  logic       rxd,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] data
);

    localparam int unsigned TW   = $clog2(DIV + 1);
    localparam int unsigned HALF = DIV / 2;

    rx_state_t     state, state_n;
    logic [1:0]    sync_q;
    logic          rx_prev;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          byte_valid_n, frame_err_n;
    logic [7:0]    data_n;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // State and datapath registers
    always_ff @(posedge clock_reg) begin
        if (reset) begin
            state      <= R_IDLE;
            sync_q     <= 2'b11;
            rx_prev    <= 1'b1;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            data       <= '0;
        end else begin
            state      <= state_n;
            sync_q     <= {sync_q[0], rxd};
            rx_prev    <= rx_s;
            timer      <= timer_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
            data       <= data_n;
        end
    end

    // Receive sequencing: half-bit start check, then full-bit sampling
    always_comb begin
        state_n      = state;
        timer_n      = timer + TW'(1);
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        data_n       = data;
        case (state)
            R_IDLE: begin
                timer_n = '0;
                if (rx_prev && !rx_s) state_n = R_START;
            end
            R_START: begin
                if (timer == TW'(HALF - 1)) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (timer == TW'(DIV - 1)) begin
                    timer_n   = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = R_STOP;
                end
            end
            R_STOP: begin
                if (timer == TW'(DIV - 1)) begin
                    timer_n = '0;
                    state_n = R_IDLE;
                    if (rx_s) begin
                        byte_valid_n = 1'b1;
                        data_n       = shreg;
                    end else begin
                        frame_err_n  = 1'b1;
                    end
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_inst_loader.sv
// Serial program loader: receives A5 / N / 4N data / checksum frames,
// writes assembled words to instruction memory, holds the core meanwhile.
//   clock_reg, reset : clock and synchronous active-high reset
//   rxd              : UART receive line
//   imem             : instruction memory write port (we/waddr/wdata)
//   cpu_hold_o       : core reset while loading or after a failed load
//   busy_o           : frame in progress
//   done_o, err_o    : last frame result
//   rx_byte_o        : last received byte (debug)
module uart_inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned WORDS  = 64
) (
    input  logic                       clock_reg,
    input  logic                       reset,
    input  logic                       rxd,
    uart_inst_loader_if.master         imem,
    output logic                       cpu_hold_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [7:0]                 rx_byte_o
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    logic byte_valid, frame_err;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clock_reg  (clock_reg),
        .reset      (reset),
        .rxd        (rxd),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .data       (rx_byte_o)
    );

    loader_state_t    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] widx, widx_n, widx_inc;
    logic [1:0]       bidx, bidx_n;
    logic [7:0]       csum, csum_n;
    logic [31:0]      word, word_n;
    logic             we_n;
    logic [7:0]       waddr_n;
    logic [31:0]      wdata_n;
    logic             hold_n, busy_n, done_n, err_n;

    assign widx_inc = widx + CNT_W'(1);

    // State, assembly and output registers
    always_ff @(posedge clock_reg) begin
        if (reset) begin
            state        <= L_IDLE;
            cnt          <= '0;
            widx         <= '0;
            bidx         <= '0;
            csum         <= '0;
            word         <= '0;
            imem.we_o    <= 1'b0;
            imem.waddr_o <= '0;
            imem.wdata_o <= '0;
            cpu_hold_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            widx         <= widx_n;
            bidx         <= bidx_n;
            csum         <= csum_n;
            word         <= word_n;
            imem.we_o    <= we_n;
            imem.waddr_o <= waddr_n;
            imem.wdata_o <= wdata_n;
            cpu_hold_o   <= hold_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            err_o        <= err_n;
        end
    end

    // Frame parsing, word assembly and status decode of the next state
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        widx_n  = widx;
        bidx_n  = bidx;
        csum_n  = csum;
        word_n  = word;
        we_n    = 1'b0;
        waddr_n = imem.waddr_o;
        wdata_n = imem.wdata_o;

        if (frame_err) begin
            if (state != L_IDLE && state != L_DONE) state_n = L_ERR;
        end else if (byte_valid) begin
            case (state)
                L_IDLE, L_DONE, L_ERR: begin
                    if (rx_byte_o == CMD_START) state_n = L_COUNT;
                end
                L_COUNT: begin
                    if (rx_byte_o == 8'h00 || 32'(rx_byte_o) > WORDS) begin
                        state_n = L_ERR;
                    end else begin
                        cnt_n   = CNT_W'(rx_byte_o);
                        widx_n  = '0;
                        bidx_n  = '0;
                        csum_n  = '0;
                        state_n = L_DATA;
                    end
                end
                L_DATA: begin
                    word_n[{bidx, 3'b000} +: 8] = rx_byte_o;
                    csum_n = csum + rx_byte_o;
                    bidx_n = bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        we_n    = 1'b1;
                        waddr_n = 8'({widx, 2'b00});
                        wdata_n = word_n;
                        widx_n  = widx_inc;
                        if (widx_inc == cnt) state_n = L_CHECK;
                    end
                end
                L_CHECK: begin
                    state_n = (rx_byte_o == csum) ? L_DONE : L_ERR;
                end
                default: state_n = L_IDLE;
            endcase
        end

        hold_n = (state_n == L_COUNT) || (state_n == L_DATA) ||
                 (state_n == L_CHECK) || (state_n == L_ERR);
        busy_n = (state_n == L_COUNT) || (state_n == L_DATA) || (state_n == L_CHECK);
        done_n = (state_n == L_DONE);
        err_n  = (state_n == L_ERR);
    end

endmodule

// File: doc/uart_inst_loader.md
# uart_inst_loader

Serial program loader for the single-cycle core. Receives a framed program image on the board UART, assembles 32-bit instruction words, and writes them sequentially into the instruction memory. It holds the core (program counter, register file, data memory) in reset while loading. It sits directly upstream of the instruction memory write port and the core reset net, so new programs run without resynthesis.

## Interface

Parameters:
- CLK_HZ, 50_000_000, frequency of clock_reg in Hz
- BAUD, 115200, UART bit rate
- WORDS, 64, instruction memory depth in 32-bit words (byte address space 8 bits, word-aligned)

Ports:
- clock_reg  in  1  system clock (CLOCK_50); one clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset (top level drives ~KEY[2])
- rxd  in  1  UART_RXD, asynchronous, idle high
- we_o  out  1  one-cycle instruction memory write strobe
- waddr_o  out  8  byte address of the word being written, always a multiple of 4
- wdata_o  out  32  instruction word, little-endian assembled
- cpu_hold_o  out  1  forces core reset while high
- busy_o  out  1  a load frame is in progress
- done_o  out  1  last frame loaded and checksum matched
- err_o  out  1  last frame failed
- rx_byte_o  out  8  last received byte, for the LCD debug view

## Operation

- Frame: 0xA5 start, then count N (1..WORDS), then 4N data bytes (LSB first within each word), then checksum = sum of data bytes mod 256.
- The receiver samples rxd through a 2-flop synchronizer. DIV = CLK_HZ/BAUD, truncated. On a falling edge it waits DIV/2 and re-checks for low; if rxd is high there, it is a false start and the receiver returns to idle. It then samples 8 data bits LSB first at DIV intervals, and the stop bit at DIV after that.
- If the stop bit is 1, the receiver pulses byte_valid for one cycle and updates rx_byte_o.
- If the stop bit is 0, the receiver pulses frame_err, and the loader goes to L_ERR unless it is in L_IDLE or L_DONE.
- Loader FSM:
  - L_IDLE: any byte other than 0xA5 is ignored; 0xA5 goes to L_COUNT.
  - L_COUNT: if the byte N is 0 or N > WORDS, go to L_ERR. Otherwise latch N, clear the word index, byte index and checksum, and go to L_DATA.
  - L_DATA: shift the byte into word position byte_idx and add it to the checksum. When byte_idx == 3, issue the write and increment the word index. After word N-1 is written, go to L_CHECK.
  - L_CHECK: if the byte equals the checksum, go to L_DONE; otherwise go to L_ERR.
  - L_DONE and L_ERR: a 0xA5 byte restarts at L_COUNT; other bytes are ignored.
- Words written before an error are left in memory, and the core stays held.
- cpu_hold_o = 1 in L_COUNT, L_DATA, L_CHECK and L_ERR; it is 0 in L_IDLE and L_DONE.
- busy_o = 1 in L_COUNT, L_DATA and L_CHECK.
- done_o = 1 only in L_DONE; err_o = 1 only in L_ERR.
- The loader has no inter-byte timeout; a stalled frame holds until reset or until a 0xA5 arrives in a state that accepts it.

## Timing

- Reset: FSM goes to L_IDLE and the receiver to idle. Outputs: we_o=0, waddr_o=0, wdata_o=0, cpu_hold_o=0, busy_o=0, done_o=0, err_o=0, rx_byte_o=0.
- Reset mid-frame aborts with no further writes, and the next frame must start with 0xA5.
- byte_valid is asserted in the cycle after the stop-bit sample.
- The FSM acts on byte_valid in that same cycle; registered outputs change on the following edge.
- we_o is high for exactly one cycle, the cycle after byte_valid of a word's 4th byte. waddr_o and wdata_o are valid in that cycle and held until the next write.
- waddr_o = 4*word_index and never wraps, because N ≤ WORDS.
- cpu_hold_o rises one cycle after the 0xA5 byte_valid.
- cpu_hold_o falls one cycle after the matching checksum byte_valid. The core then starts from PC=0.
- byte_valid and frame_err are mutually exclusive, since they are derived from the same stop sample.

## Structure

- loader_pkg holds the loader state enum, CMD_START = 8'hA5, and a function computing DIV from CLK_HZ and BAUD.
- Sub-module uart_rx_byte contains the synchronizer, the bit timer, the receive FSM (R_IDLE, R_START, R_DATA, R_STOP), and the byte_valid, frame_err and data outputs.
- The loader FSM and word assembly live in uart_inst_loader.

## Test plan

Unless noted, the bench uses CLK_HZ=1000 and BAUD=100, giving DIV=10.

- Good frame: send A5 01 13 05 10 00 28. Expect one we_o pulse with waddr_o=0x00 and wdata_o=0x00100513, then done_o=1, cpu_hold_o=0 and err_o=0.
- Two words: send A5 02, then bytes 01..08, then checksum 24. Expect writes of 0x04030201 at 0x00 and 0x08070605 at 0x04, then done_o=1.
- Bad checksum: the good frame with its last byte 00. Expect the word written, then err_o=1 with cpu_hold_o still 1. Resend the good frame: expect done_o=1.
- Bad count: send A5 00, and separately A5 41. Expect err_o=1 with no we_o in either case.
- Line faults:
  - A 3-cycle low glitch on rxd gives no byte_valid.
  - A low stop bit during L_DATA gives err_o=1.
  - Junk byte 3C in L_IDLE is ignored.
- Reset mid-frame: assert reset after A5 02 and 5 data bytes. Expect all outputs at reset values, and no further we_o until a new frame arrives.
